// File: rtl/alu_status.sv
// Result/status stage behind the ALU: registers each result, runs the NMOS
// decimal fix-up over two extra cycles when P.D is set, and maintains P.
module alu_status (
  input  logic       clk,
  input  logic       resetb,
  input  logic       alu_valid,
  input  logic [3:0] alu_op,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic       alu_c_out,
  input  logic [3:0] flag_we,
  input  logic       p_load,
  input  logic [7:0] p_in,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [7:0] p_out,
  output logic       c_flag
);
  typedef enum logic [1:0] {IDLE, ADJ_LO, ADJ_HI} state_t;

  state_t     state, state_nxt;
  logic [7:0] t_q, p_q, p_nxt;
  logic       c_q, hc_q, v_q, sub_q;
  logic [3:0] we_q;
  logic       dec_op, hc_in, acc_bin, acc_dec;

  logic [8:0] lo_sum9;
  logic [7:0] lo_t, hi_t;
  logic       lo_c, hi_c;

  logic       commit;
  logic [7:0] cm_y;
  logic [3:0] cm_f, cm_we;

  assign dec_op  = (alu_op == 4'd2) || (alu_op == 4'd3);
  // Half carry out of bit 3, recovered from the operands and the sum's bit 4.
  assign hc_in   = (((alu_op == 4'd3) ? ~alu_a : alu_a) ^ alu_b ^ alu_y) & 8'h10 ? 1'b1 : 1'b0;
  assign lo_sum9 = {1'b0, t_q} + 9'h006;

  always_comb begin
    state_nxt = state;
    acc_bin   = 1'b0;
    acc_dec   = 1'b0;
    case (state)
      IDLE: if (alu_valid) begin
        if (p_q[3] && dec_op) begin
          acc_dec   = 1'b1;
          state_nxt = ADJ_LO;
        end else begin
          acc_bin   = 1'b1;
        end
      end
      ADJ_LO:  state_nxt = ADJ_HI;
      ADJ_HI:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lo_t = t_q;
    lo_c = c_q;
    hi_t = t_q;
    hi_c = c_q;
    if (sub_q) begin
      if (!hc_q) lo_t = t_q + 8'hFA;
      if (!c_q)  hi_t = t_q + 8'hA0;
    end else begin
      if (hc_q || (t_q[3:0] > 4'd9)) begin
        lo_t = lo_sum9[7:0];
        lo_c = c_q | lo_sum9[8];
      end
      if (c_q || (t_q[7:4] > 4'd9)) begin
        hi_t = t_q + 8'h60;
        hi_c = 1'b1;
      end
    end
  end

  // Flag bundles are ordered {N,V,Z,C} to line up with flag_we.
  always_comb begin
    commit = 1'b0;
    cm_y   = alu_y;
    cm_f   = {alu_negative, alu_overflow, alu_zero, alu_c_out};
    cm_we  = flag_we;
    if (acc_bin) begin
      commit = 1'b1;
    end else if (state == ADJ_HI) begin
      commit = 1'b1;
      cm_y   = hi_t;
      cm_f   = {hi_t[7], v_q, hi_t == 8'h00, hi_c};
      cm_we  = we_q;
    end
  end

  always_comb begin
    p_nxt = p_q;
    if (commit) begin
      if (cm_we[3]) p_nxt[7] = cm_f[3];
      if (cm_we[2]) p_nxt[6] = cm_f[2];
      if (cm_we[1]) p_nxt[1] = cm_f[1];
      if (cm_we[0]) p_nxt[0] = cm_f[0];
    end
    if (p_load) p_nxt = p_in;
    p_nxt[5] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state        <= IDLE;
      p_q          <= 8'h24;
      result       <= 8'h00;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      t_q          <= 8'h00;
      c_q          <= 1'b0;
      hc_q         <= 1'b0;
      v_q          <= 1'b0;
      sub_q        <= 1'b0;
      we_q         <= 4'h0;
    end else begin
      state        <= state_nxt;
      p_q          <= p_nxt;
      result_valid <= commit;
      busy         <= (state_nxt != IDLE);
      if (commit) result <= cm_y;
      if (acc_dec) begin
        t_q   <= alu_y;
        c_q   <= alu_c_out;
        hc_q  <= hc_in;
        v_q   <= alu_overflow;
        sub_q <= (alu_op == 4'd3);
        we_q  <= flag_we;
      end else if (state == ADJ_LO) begin
        t_q <= lo_t;
        c_q <= lo_c;
      end
    end
  end

  assign p_out  = p_q;
  assign c_flag = p_q[0];
endmodule

// File: tb/tb_alu_status.sv
// Directed bench for alu_status: a cycle-level reference model checked every
// cycle, plus literal checks on the hand-worked cases.
module tb_alu_status;
  logic       clk = 1'b0;
  logic       resetb, alu_valid, alu_zero, alu_negative, alu_overflow, alu_c_out, p_load;
  logic [3:0] alu_op, flag_we;
  logic [7:0] alu_a, alu_b, alu_y, p_in;
  logic [7:0] result, p_out;
  logic       result_valid, busy, c_flag;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  alu_status dut (
    .clk(clk), .resetb(resetb), .alu_valid(alu_valid), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow), .alu_c_out(alu_c_out),
    .flag_we(flag_we), .p_load(p_load), .p_in(p_in), .result(result),
    .result_valid(result_valid), .busy(busy), .p_out(p_out), .c_flag(c_flag)
  );

  always #5 clk = ~clk;

  // Reference model: a decimal op is resolved in one go at accept time and
  // its commit is simply delayed by a countdown.
  typedef struct {
    logic [7:0] p;
    logic [7:0] res;
    logic       rv;
    int         cnt;
    logic [7:0] pend_res;
    logic [3:0] pend_f;
    logic [3:0] pend_we;
  } mstate_t;

  mstate_t m;

  function automatic logic [7:0] apply(logic [7:0] p, logic [3:0] we, logic [3:0] f);
    logic [7:0] r;
    r = p;
    if (we[3]) r[7] = f[3];
    if (we[2]) r[6] = f[2];
    if (we[1]) r[1] = f[1];
    if (we[0]) r[0] = f[0];
    return r;
  endfunction

  function automatic logic [8:0] bcd(logic [3:0] op, logic [7:0] a, logic [7:0] b,
                                     logic [7:0] y, logic cout);
    int ea, t, c, hc;
    ea = (op == 4'd3) ? (255 - int'(a)) : int'(a);
    hc = ((ea ^ int'(b) ^ int'(y)) / 16) % 2;
    t  = int'(y);
    c  = int'(cout);
    if (op == 4'd3) begin
      if (hc == 0) t = (t + 250) % 256;
      if (c == 0)  t = (t + 160) % 256;
    end else begin
      if (hc != 0 || t % 16 > 9) begin
        t = t + 6;
        if (t > 255) c = 1;
        t = t % 256;
      end
      if (c != 0 || t / 16 > 9) begin
        t = (t + 96) % 256;
        c = 1;
      end
    end
    return 9'(c * 256 + t);
  endfunction

  function automatic mstate_t step(mstate_t s);
    mstate_t    n;
    logic [8:0] d;
    n    = s;
    n.rv = 1'b0;
    if (!resetb) begin
      n.p   = 8'h24;
      n.res = 8'h00;
      n.cnt = 0;
      return n;
    end
    if (s.cnt == 2) begin
      n.cnt = 1;
    end else if (s.cnt == 1) begin
      n.cnt = 0;
      n.res = s.pend_res;
      n.rv  = 1'b1;
      n.p   = apply(s.p, s.pend_we, s.pend_f);
    end else if (alu_valid) begin
      if (s.p[3] && (alu_op == 4'd2 || alu_op == 4'd3)) begin
        d          = bcd(alu_op, alu_a, alu_b, alu_y, alu_c_out);
        n.pend_res = d[7:0];
        n.pend_f   = {d[7], alu_overflow, d[7:0] == 8'h00, d[8]};
        n.pend_we  = flag_we;
        n.cnt      = 2;
      end else begin
        n.res = alu_y;
        n.rv  = 1'b1;
        n.p   = apply(s.p, flag_we, {alu_negative, alu_overflow, alu_zero, alu_c_out});
      end
    end
    if (p_load) n.p = p_in | 8'h20;
    return n;
  endfunction

  always @(posedge clk) m <= step(m);

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model result", result, m.res);
      cmp("model result_valid", {7'd0, result_valid}, {7'd0, m.rv});
      cmp("model busy", {7'd0, busy}, {7'd0, m.cnt != 0});
      cmp("model p_out", p_out, m.p);
      cmp("model c_flag", {7'd0, c_flag}, {7'd0, m.p[0]});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_alu(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] y,
                         logic n, logic v, logic z, logic c, logic [3:0] we);
    alu_valid = 1'b1; alu_op = op; alu_a = a; alu_b = b; alu_y = y;
    alu_negative = n; alu_overflow = v; alu_zero = z; alu_c_out = c; flag_we = we;
  endtask

  int rv_cnt;

  initial begin
    resetb = 1'b0; alu_valid = 1'b0; alu_op = 4'd0; alu_a = 8'h00; alu_b = 8'h00;
    alu_y = 8'h00; alu_zero = 1'b0; alu_negative = 1'b0; alu_overflow = 1'b0;
    alu_c_out = 1'b0; flag_we = 4'h0; p_load = 1'b0; p_in = 8'h00;
    tick();
    tick();
    resetb = 1'b1;
    chk_en = 1'b1;
    cmp("reset p_out", p_out, 8'h24);
    cmp("reset result", result, 8'h00);
    cmp("reset result_valid", {7'd0, result_valid}, 8'h00);
    cmp("reset busy", {7'd0, busy}, 8'h00);
    cmp("reset c_flag", {7'd0, c_flag}, 8'h00);

    // Binary add
    set_alu(4'd2, 8'h50, 8'h50, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
    tick();
    alu_valid = 1'b0;
    cmp("bin result", result, 8'hA0);
    cmp("bin result_valid", {7'd0, result_valid}, 8'h01);
    cmp("bin p_out", p_out, 8'hE4);

    p_load = 1'b1; p_in = 8'h08;
    tick();
    p_load = 1'b0;
    cmp("p_load D", p_out, 8'h28);

    // Decimal add with carry out
    set_alu(4'd2, 8'h58, 8'h46, 8'h9F, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    tick();
    alu_valid = 1'b0;
    cmp("dec busy 1", {7'd0, busy}, 8'h01);
    tick();
    cmp("dec busy 2", {7'd0, busy}, 8'h01);
    cmp("dec no rv yet", {7'd0, result_valid}, 8'h00);
    tick();
    cmp("dec add result", result, 8'h05);
    cmp("dec add rv", {7'd0, result_valid}, 8'h01);
    cmp("dec add busy low", {7'd0, busy}, 8'h00);
    cmp("dec add c_flag", {7'd0, c_flag}, 8'h01);
    cmp("dec add p_out", p_out, 8'h29);

    // Decimal add without carry
    set_alu(4'd2, 8'h19, 8'h28, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    tick(); alu_valid = 1'b0; tick(); tick();
    cmp("dec add2 result", result, 8'h47);
    cmp("dec add2 p_out", p_out, 8'h28);

    // Decimal subtract, then a binary op accepted as busy drops
    set_alu(4'd3, 8'h15, 8'h42, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    tick(); alu_valid = 1'b0; tick(); tick();
    cmp("dec sub result", result, 8'h27);
    cmp("dec sub p_out", p_out, 8'h29);
    set_alu(4'd0, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    alu_valid = 1'b0;
    cmp("after busy result", result, 8'h00);
    cmp("after busy p_out", p_out, 8'h2B);

    // alu_valid during busy is dropped
    set_alu(4'd2, 8'h58, 8'h46, 8'h9F, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    tick();
    set_alu(4'd0, 8'h33, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    tick();
    alu_valid = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (result_valid) rv_cnt++;
    end
    cmp("drop rv count", 8'(rv_cnt), 8'h01);
    cmp("drop result", result, 8'h05);

    // p_load on the commit edge wins over the flag update
    set_alu(4'd2, 8'h19, 8'h28, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    tick(); alu_valid = 1'b0; tick();
    p_load = 1'b1; p_in = 8'hFF;
    tick();
    p_load = 1'b0;
    cmp("load on commit p_out", p_out, 8'hFF);
    cmp("load on commit result", result, 8'h47);

    // Reset while in ADJ_HI aborts
    set_alu(4'd2, 8'h19, 8'h28, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    tick(); alu_valid = 1'b0; tick();
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    cmp("abort rv", {7'd0, result_valid}, 8'h00);
    cmp("abort p_out", p_out, 8'h24);
    cmp("abort busy", {7'd0, busy}, 8'h00);
    cmp("abort result", result, 8'h00);

    // Back-to-back binary, masked flags, and p_load beside a commit
    set_alu(4'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    cmp("b2b z p_out", p_out, 8'h26);
    set_alu(4'd5, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8);
    tick();
    cmp("b2b n p_out", p_out, 8'hA6);
    set_alu(4'd1, 8'h11, 8'h00, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    tick();
    cmp("b2b nowe p_out", p_out, 8'hA6);
    cmp("b2b nowe result", result, 8'h11);
    set_alu(4'd2, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
    p_load = 1'b1; p_in = 8'h00;
    tick();
    alu_valid = 1'b0; p_load = 1'b0;
    cmp("load+bin p_out", p_out, 8'h20);
    cmp("load+bin result", result, 8'hFF);
    cmp("load+bin rv", {7'd0, result_valid}, 8'h01);
    tick();
    cmp("rv one cycle", {7'd0, result_valid}, 8'h00);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
